// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - DDS phase accumulator with phase-continuous retuning.
// Optional linear frequency sweep is enabled by defining DDS_SWEEP_EN.
module dds_phase_gen #(
    parameter int PHASE_W    = 32,
    parameter int ADDR_W     = 8,
    parameter int SEL_W      = 3,
    parameter int BASE_SHIFT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [PHASE_W-1:0] fword,
    input  logic               load,
`ifdef DDS_SWEEP_EN
    input  logic               sweep_on,
    input  logic [PHASE_W-1:0] sweep_step,
    input  logic [PHASE_W-1:0] sweep_limit,
`endif
    output logic               busy,
    output logic [ADDR_W-1:0]  out_address,
    output logic               wrap
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_PEND} state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] active_inc_q, active_inc_d;
    logic [PHASE_W-1:0] pend_inc_q, pend_inc_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic [PHASE_W-1:0] oct_inc;
    logic [PHASE_W-1:0] new_inc;
    logic [PHASE_W-1:0] stop_inc;
    logic               apply_pend;

`ifdef DDS_SWEEP_EN
    logic [PHASE_W-1:0] base_inc_q, base_inc_d;
    logic [PHASE_W:0]   sweep_sum;
`endif

    always_comb begin
        sum        = {1'b0, phase_q} + {1'b0, active_inc_q};
        carry      = en & sum[PHASE_W];
        oct_inc    = PHASE_W'(1) << (32'(sel) + BASE_SHIFT);
        new_inc    = mode ? fword : oct_inc;
        stop_inc   = busy_q ? pend_inc_q : active_inc_q;
        apply_pend = 1'b0;

        state_d      = state_q;
        phase_d      = phase_q;
        active_inc_d = active_inc_q;
        pend_inc_d   = pend_inc_q;
        busy_d       = busy_q;
        wrap_d       = carry;
`ifdef DDS_SWEEP_EN
        base_inc_d   = base_inc_q;
        sweep_sum    = {1'b0, active_inc_q} + {1'b0, sweep_step};
`endif

        if (en) begin
            phase_d = sum[PHASE_W-1:0];
        end
        if (load) begin
            pend_inc_d = new_inc;
            busy_d     = 1'b1;
        end

        case (state_q)
            ST_STOP: begin
                // A load arriving here is applied on the following edge.
                if (!load) begin
                    apply_pend = busy_q;
                    busy_d     = 1'b0;
                    state_d    = (en && stop_inc != '0) ? ST_RUN : ST_STOP;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                end else if (load) begin
                    state_d = ST_PEND;
                end
`ifdef DDS_SWEEP_EN
                if (carry && sweep_on) begin
                    if (sweep_sum[PHASE_W] || sweep_sum[PHASE_W-1:0] > sweep_limit) begin
                        active_inc_d = base_inc_q;
                    end else begin
                        active_inc_d = sweep_sum[PHASE_W-1:0];
                    end
                end
`endif
            end
            ST_PEND: begin
                if (!en) begin
                    apply_pend = 1'b1;
                    busy_d     = load;
                    state_d    = ST_STOP;
                end else if (carry) begin
                    apply_pend = 1'b1;
                    busy_d     = load;
                    if (pend_inc_q == '0) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = load ? ST_PEND : ST_RUN;
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase

        if (apply_pend) begin
            active_inc_d = pend_inc_q;
`ifdef DDS_SWEEP_EN
            base_inc_d   = pend_inc_q;
`endif
        end

        addr_d = phase_d[PHASE_W-1 -: ADDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_STOP;
            phase_q      <= '0;
            active_inc_q <= '0;
            pend_inc_q   <= '0;
            busy_q       <= 1'b0;
            wrap_q       <= 1'b0;
            addr_q       <= '0;
`ifdef DDS_SWEEP_EN
            base_inc_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            active_inc_q <= active_inc_d;
            pend_inc_q   <= pend_inc_d;
            busy_q       <= busy_d;
            wrap_q       <= wrap_d;
            addr_q       <= addr_d;
`ifdef DDS_SWEEP_EN
            base_inc_q   <= base_inc_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign wrap        = wrap_q;
    assign out_address = addr_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - directed self-checking bench for dds_phase_gen.
module tb_dds_phase_gen;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 8;
    localparam int SEL_W   = 3;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [PHASE_W-1:0] fword;
    logic               load;
    logic               busy;
    logic [ADDR_W-1:0]  out_address;
    logic               wrap;
`ifdef DDS_SWEEP_EN
    logic               sweep_on;
    logic [PHASE_W-1:0] sweep_step;
    logic [PHASE_W-1:0] sweep_limit;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    dds_phase_gen #(
        .PHASE_W    (PHASE_W),
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W),
        .BASE_SHIFT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .sel         (sel),
        .fword       (fword),
        .load        (load),
`ifdef DDS_SWEEP_EN
        .sweep_on    (sweep_on),
        .sweep_step  (sweep_step),
        .sweep_limit (sweep_limit),
`endif
        .busy        (busy),
        .out_address (out_address),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until wrap is seen (or max expires); notes any drop of busy before the wrap.
    task automatic run_to_wrap(input int max, output int n, output bit busy_dropped);
        n = 0;
        busy_dropped = 1'b0;
        while (n < max) begin
            tick();
            n++;
            if (wrap) break;
            if (!busy) busy_dropped = 1'b1;
        end
    endtask

    task automatic run_to_addr(input logic [ADDR_W-1:0] target, input string tag);
        int n;
        n = 0;
        while (out_address != target && n < 300) begin
            tick();
            n++;
        end
        check(tag, {24'd0, out_address}, {24'd0, target});
    endtask

    initial begin
        int  n;
        bit  bd;
        logic [ADDR_W-1:0] a0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; fword = '0; load = 1'b0;
`ifdef DDS_SWEEP_EN
        sweep_on = 1'b0; sweep_step = '0; sweep_limit = '0;
`endif
        repeat (3) tick();
        check("rst_addr", {24'd0, out_address}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_wrap", {31'd0, wrap}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Octave 0 from STOP: busy for one cycle, then +1 per clock
        en = 1'b1; mode = 1'b0; sel = 3'd0; load = 1'b1;
        tick();
        check("stop_load_busy", {31'd0, busy}, 32'h1);
        load = 1'b0;
        tick();
        check("stop_apply_busy", {31'd0, busy}, 32'h0);
        check("stop_apply_addr", {24'd0, out_address}, 32'h0);
        tick();
        check("count_1", {24'd0, out_address}, 32'h1);
        tick();
        check("count_2", {24'd0, out_address}, 32'h2);
        run_to_wrap(300, n, bd);
        check("first_wrap_dist", n, 254);
        check("first_wrap_addr", {24'd0, out_address}, 32'h0);
        run_to_wrap(300, n, bd);
        check("wrap_period", n, 256);

        // Retune to octave 2 at 0x40; takes effect only at the wrap
        run_to_addr(8'h40, "reach_40");
        load = 1'b1; sel = 3'd2;
        tick();
        check("pend_busy", {31'd0, busy}, 32'h1);
        check("pend_addr_41", {24'd0, out_address}, 32'h41);
        load = 1'b0;
        run_to_wrap(300, n, bd);
        check("pend_wrap_dist", n, 191);
        check("pend_busy_held", {31'd0, bd}, 32'h0);
        check("pend_busy_clr", {31'd0, busy}, 32'h0);
        check("pend_wrap_addr", {24'd0, out_address}, 32'h0);
        tick();
        check("step4_a", {24'd0, out_address}, 32'h4);
        tick();
        check("step4_b", {24'd0, out_address}, 32'h8);

        // en=0 with a load pending: hold address, apply immediately, no wrap
        run_to_addr(8'h7C, "reach_7c");
        load = 1'b1; mode = 1'b1; fword = 16'h0100;
        tick();
        check("hold_load_addr", {24'd0, out_address}, 32'h80);
        load = 1'b0; en = 1'b0;
        tick();
        check("hold_addr", {24'd0, out_address}, 32'h80);
        check("hold_busy", {31'd0, busy}, 32'h0);
        check("hold_wrap", {31'd0, wrap}, 32'h0);
        tick();
        check("hold_addr2", {24'd0, out_address}, 32'h80);
        en = 1'b1;
        tick();
        check("reen_a", {24'd0, out_address}, 32'h81);
        tick();
        check("reen_b", {24'd0, out_address}, 32'h82);

        // Two loads while busy: latest (0x0300) wins
        load = 1'b1; mode = 1'b0; sel = 3'd1;
        tick();
        check("dbl_addr_a", {24'd0, out_address}, 32'h83);
        mode = 1'b1; fword = 16'h0300;
        tick();
        check("dbl_addr_b", {24'd0, out_address}, 32'h84);
        check("dbl_busy", {31'd0, busy}, 32'h1);
        load = 1'b0;
        run_to_wrap(300, n, bd);
        check("dbl_wrap_dist", n, 124);
        check("dbl_busy_held", {31'd0, bd}, 32'h0);
        check("dbl_wrap_addr", {24'd0, out_address}, 32'h0);
        tick();
        check("step3_a", {24'd0, out_address}, 32'h3);
        tick();
        check("step3_b", {24'd0, out_address}, 32'h6);

        // fword=0: freeze after the wrap, no further wrap pulses
        load = 1'b1; fword = 16'h0000;
        tick();
        check("zero_load_addr", {24'd0, out_address}, 32'h9);
        load = 1'b0;
        run_to_wrap(300, n, bd);
        check("zero_wrap_dist", n, 83);
        check("zero_wrap_addr", {24'd0, out_address}, 32'h2);
        run_to_wrap(300, n, bd);
        check("zero_no_wrap", n, 300);
        check("zero_frozen", {24'd0, out_address}, 32'h2);
        check("zero_busy", {31'd0, busy}, 32'h0);

        // Restart from STOP, then async reset mid-run with a load pending
        load = 1'b1; mode = 1'b0; sel = 3'd0;
        tick();
        check("restart_busy", {31'd0, busy}, 32'h1);
        load = 1'b0;
        tick();
        check("restart_addr", {24'd0, out_address}, 32'h2);
        tick();
        check("restart_run", {24'd0, out_address}, 32'h3);
        load = 1'b1; sel = 3'd1;
        tick();
        load = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_addr", {24'd0, out_address}, 32'h0);
        check("async_rst_busy", {31'd0, busy}, 32'h0);
        check("async_rst_wrap", {31'd0, wrap}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef DDS_SWEEP_EN
        sweep_on = 1'b1; sweep_step = 16'h0100; sweep_limit = 16'h0400;
        en = 1'b1; mode = 1'b1; fword = 16'h0100; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            run_to_wrap(300, n, bd);
            a0 = out_address;
            tick();
            check("sweep_step", {24'd0, out_address - a0}, (i == 3) ? 32'h1 : 32'(i + 2));
        end
`else
        a0 = '0;
        check("post_rst_addr", {24'd0, out_address}, {24'd0, a0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
